// File: rtl/stream_mux_pkg.sv
// Shared encodings and the round-robin pick helper for the stream mux.
// The packet-lock option is enabled by defining STREAM_MUX_PKT_LOCK_EN.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bound on channel count supported by rr_pick.
  localparam int MAX_CH = 64;

  function automatic logic [MAX_CH-1:0] rr_pick(
    input logic [MAX_CH-1:0] req,
    input logic [5:0]        ptr,
    input int                n
  );
    logic [MAX_CH-1:0] g;
    logic              found;
    logic [6:0]        idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n && !found) begin
        idx = {1'b0, ptr} + 7'(i);
        if (idx >= 7'(n)) idx = idx - 7'(n);
        if (req[idx[5:0]]) begin
          g[idx[5:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// Grant generation: fixed select or round-robin, plus rr pointer and optional packet lock
// (STREAM_MUX_PKT_LOCK_EN). Grant is combinational; state updates on accepted beats only.
module stream_mux_rr_arb
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N_CH-1:0]  in_valid,
  input  logic [N_CH-1:0]  in_last,
  input  logic             load,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] next_ptr;
  logic [N_CH-1:0]  fix_grant;
  logic [N_CH-1:0]  rr_grant;
  logic [N_CH-1:0]  base_grant;
  logic             xfer;
  logic             xfer_last;

  always_comb begin
    fix_grant = '0;
    if (32'(sel) < N_CH) fix_grant[sel] = 1'b1;
  end

  assign rr_grant   = N_CH'(rr_pick(MAX_CH'(in_valid), 6'(rr_ptr), N_CH));
  assign base_grant = (mode == MODE_RR) ? rr_grant : fix_grant;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_ch;

  // While a packet is open the grant is pinned regardless of mode, sel or valid.
  always_comb begin
    grant = base_grant;
    if (lock) begin
      grant          = '0;
      grant[lock_ch] = 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign grant       = base_grant;
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) grant_idx = SEL_W'(i);
    end
  end

  assign xfer      = load & (|(in_valid & grant));
  assign xfer_last = |(in_last & grant);
  assign next_ptr  = (32'(grant_idx) == N_CH - 1) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (xfer && mode == MODE_RR && xfer_last) rr_ptr <= next_ptr;
`else
      if (xfer && mode == MODE_RR) rr_ptr <= next_ptr;
`endif
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      lock    <= !xfer_last;
      lock_ch <= grant_idx;
    end
  end
`endif

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux, fixed or round-robin select; optional STREAM_MUX_PKT_LOCK_EN.
// Latency 1 clk through one output register; in_ready drops while a beat is held and out_ready=0.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 11,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_last
);

  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load;
  logic              xfer;
  logic [DATA_W-1:0] cur_data;
  logic              cur_last;

  assign load = !out_valid | out_ready;

  stream_mux_rr_arb #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .load      (load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Hold ready low while reset is asserted so producers never see a phantom accept.
  assign in_ready = rst_n ? ({N_CH{load}} & grant) : '0;
  assign xfer     = |(in_valid & in_ready);
  assign cur_data = in_data[grant_idx*DATA_W +: DATA_W];
  assign cur_last = in_last[grant_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cur_data;
      out_ch    <= grant_idx;
      out_last  <= cur_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed checks of stream_mux_rr: fixed select, round-robin order, backpressure, lock, reset.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [87:0] in_data;
  logic [7:0]  in_last;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [2:0]  out_ch;
  logic        out_last;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(8), .DATA_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [10:0] v);
    in_data[ch*11 +: 11] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 3'd0;
    in_valid  = 8'hFF;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_ch",    32'(out_ch),    0);
    chk("rst_out_last",  32'(out_last),  0);
    chk("rst_in_ready",  32'(in_ready),  0);
    step();
    step();
    rst_n    = 1'b1;
    in_valid = 8'h00;
    step();

    // Fixed select on channel 3.
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; put(3, 11'h5A5);
    #1 chk("t1_in_ready", 32'(in_ready), 32'h08);
    step();
    in_valid = 8'h00;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data",  32'(out_data),  32'h5A5);
    chk("t1_ch",    32'(out_ch),    3);
    step();
    chk("t1_drain", 32'(out_valid), 0);

    // Round-robin over all channels, one beat per clock.
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 8; i++) put(i, 11'(32'h100 + i));
    in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t2_ch%0d", i),   32'(out_ch),    32'(i % 8));
      chk($sformatf("t2_vld%0d", i),  32'(out_valid), 1);
      chk($sformatf("t2_data%0d", i), 32'(out_data),  32'h100 + 32'(i % 8));
    end

    // Wrap-around fairness between channels 0 and 7.
    do_reset();
    in_valid = 8'h81;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3_ch%0d", i), 32'(out_ch), (i % 2 == 0) ? 0 : 7);
    end

    // Backpressure: beat held for 4 clocks, then the next beat follows one clock after release.
    do_reset();
    mode = 1'b0; sel = 3'd5; in_valid = 8'h20; put(5, 11'h0AB); out_ready = 1'b0;
    step();
    chk("t4_first", 32'(out_data), 32'h0AB);
    put(5, 11'h155);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t4_hold%0d", i),  32'(out_data),  32'h0AB);
      chk($sformatf("t4_vld%0d", i),   32'(out_valid), 1);
      chk($sformatf("t4_rdy%0d", i),   32'(in_ready),  0);
    end
    out_ready = 1'b1;
    #1 chk("t4_rdy_release", 32'(in_ready), 32'h20);
    step();
    chk("t4_next", 32'(out_data), 32'h155);
    in_valid = 8'h00;
    step();

    // Channel 2 packet while channel 1 also requests.
    do_reset();
    mode = 1'b0; sel = 3'd2; in_valid = 8'h06; in_last = 8'h00;
    put(1, 11'h011); put(2, 11'h022);
    step();
    chk("t5_b0", 32'(out_ch), 2);
    mode = 1'b1;
    step();
`ifdef STREAM_MUX_PKT_LOCK_EN
    chk("t5_b1", 32'(out_ch), 2);
    in_last = 8'h04;
    step();
    chk("t5_b2", 32'(out_ch), 2);
    chk("t5_b2_last", 32'(out_last), 1);
    in_last = 8'h00;
    step();
    chk("t5_b3", 32'(out_ch), 1);
`else
    chk("t5_b1", 32'(out_ch), 1);
    in_last = 8'h04;
    step();
    chk("t5_b2", 32'(out_ch), 2);
    chk("t5_b2_last", 32'(out_last), 1);
    in_last = 8'h00;
    step();
    chk("t5_b3", 32'(out_ch), 1);
`endif
    in_valid = 8'h00;
    step();

    // Reset mid-stream: beat dropped, pointer back to zero.
    do_reset();
    mode = 1'b1; in_valid = 8'hFF;
    step(); step(); step();
    chk("t6_pre_ch", 32'(out_ch), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(out_valid), 0);
    chk("t6_rst_rdy", 32'(in_ready),  0);
    step();
    rst_n    = 1'b1;
    in_valid = 8'h24;
    #1 chk("t6_rdy", 32'(in_ready), 32'h04);
    step();
    chk("t6_vld", 32'(out_valid), 1);
    chk("t6_ch",  32'(out_ch),    2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
